// File: rtl/pulse_timer_pkg.sv
// Shared definitions for the tick-gated event timer: FSM encoding and default width.
package pulse_timer_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pulse_gated_timer_tick_down_counter.sv
// WIDTH-bit down-counter with synchronous clear/load/enable and a terminal (count==1) flag.
// Priority inside the counter: clear > load > enable. Decrement saturates at 0.
module tick_down_counter
    import pulse_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    // Next count: clear wins over load, load over decrement; never wraps below zero.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_value;
        end else if (enable && (count_reg != '0)) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count    = count_reg;
    assign terminal = (count_reg == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/pulse_gated_timer.sv
// Tick-gated programmable timer: IDLE/RUN FSM, one-shot or auto-reload expiry,
// PENDING/ACK handshake and sticky OVERRUN for events lost to a slow consumer.
module pulse_gated_timer
    import pulse_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             TICK,
    input  logic             START,
    input  logic             STOP,
    input  logic             AUTO_RELOAD,
    input  logic [WIDTH-1:0] PERIOD,
    input  logic             ACK,
    input  logic             CLR_OVERRUN,
    output logic             BUSY,
    output logic [WIDTH-1:0] COUNT,
    output logic             PENDING,
    output logic             OVERRUN
);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_next;
    logic             mode_reg;
    logic             mode_next;
    logic             pending_reg;
    logic             pending_next;
    logic             overrun_reg;
    logic             overrun_next;

    logic             cnt_clear;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_value;
    logic             cnt_enable;
    logic             cnt_terminal;
    logic [WIDTH-1:0] cnt_value;
    logic             expiry;
    logic             period_nz;

    assign period_nz = (PERIOD != '0);

    tick_down_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk        (CLK),
        .rst_n      (RST_N),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .enable     (cnt_enable),
        .count      (cnt_value),
        .terminal   (cnt_terminal)
    );

    // Next-state, counter control and event handshake; STOP > START > TICK.
    always_comb begin
        state_next     = state_reg;
        reload_next    = reload_reg;
        mode_next      = mode_reg;
        cnt_clear      = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_value = PERIOD;
        cnt_enable     = 1'b0;
        expiry         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (START && !STOP && period_nz) begin
                    cnt_load    = 1'b1;
                    reload_next = PERIOD;
                    mode_next   = AUTO_RELOAD;
                    state_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (STOP || (START && !period_nz)) begin
                    // Abort: no expiry even if this is the final tick.
                    cnt_clear  = 1'b1;
                    state_next = ST_IDLE;
                end else if (START) begin
                    // Restart discards any tick arriving in the same cycle.
                    cnt_load    = 1'b1;
                    reload_next = PERIOD;
                    mode_next   = AUTO_RELOAD;
                end else if (TICK) begin
                    if (cnt_terminal) begin
                        expiry = 1'b1;
                        if (mode_reg) begin
                            cnt_load       = 1'b1;
                            cnt_load_value = reload_reg;
                        end else begin
                            cnt_clear  = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end else begin
                        cnt_enable = 1'b1;
                    end
                end
            end
            default: begin
                cnt_clear  = 1'b1;
                state_next = ST_IDLE;
            end
        endcase

        // A new expiry outranks ACK; ACK with nothing pending is harmless.
        if (expiry) begin
            pending_next = 1'b1;
        end else if (ACK) begin
            pending_next = 1'b0;
        end else begin
            pending_next = pending_reg;
        end

        // Overrun: event lost because the previous one was still unacknowledged.
        if (expiry && pending_reg && !ACK) begin
            overrun_next = 1'b1;
        end else if (CLR_OVERRUN) begin
            overrun_next = 1'b0;
        end else begin
            overrun_next = overrun_reg;
        end
    end

    // State, configuration and event registers, all cleared asynchronously.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= ST_IDLE;
            reload_reg  <= '0;
            mode_reg    <= 1'b0;
            pending_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            reload_reg  <= reload_next;
            mode_reg    <= mode_next;
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
        end
    end

    assign BUSY    = (state_reg == ST_RUN);
    assign COUNT   = cnt_value;
    assign PENDING = pending_reg;
    assign OVERRUN = overrun_reg;

endmodule
